// File: rtl/op_seq_pkg.sv
// op_seq_pkg: shared definitions for the op_sequencer slice.
//   - Opcode values driven onto the datapath Sel input.
//   - FSM state encoding used by op_sequencer.
package op_seq_pkg;

    localparam logic [1:0] OP_XOR  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XNOR = 2'd2;
    localparam logic [1:0] OP_AND  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/op_prog_mem.sv
// op_prog_mem: DEPTH x 2-bit program register file.
//   clk     - clock, writes on posedge
//   rst     - asynchronous active-high clear of every entry
//   wr_en   - write strobe (already qualified by the caller)
//   wr_addr - write address
//   wr_op   - opcode to store
//   rd_addr - read address
//   rd_op   - combinational read data
module op_prog_mem
    import op_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_op,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_op
);

    logic [1:0] mem_r [DEPTH];

    // Program storage: cleared on reset, single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= OP_XOR;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_op;
        end
    end

    assign rd_op = mem_r[rd_addr];

endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: steps a stored opcode program onto the datapath Sel input.
//   Clk, Rst        - clock / asynchronous active-high reset
//   WrEn/WrAddr/WrOp- program write port (ignored while running)
//   Start, Len      - run request and step count (clamped to DEPTH)
//   Reps            - extra passes, present only with OP_SEQ_LOOP_EN
//   MuxOut          - datapath result, captured on the final step
//   Sel, Busy, Done, Step, Result - datapath select and run status
// Optional feature macro: OP_SEQ_LOOP_EN (repeat the program Reps+1 times).
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [1:0]    WrOp,
    input  logic          Start,
    input  logic [AW:0]   Len,
`ifdef OP_SEQ_LOOP_EN
    input  logic [3:0]    Reps,
`endif
    input  logic [7:0]    MuxOut,
    output logic [1:0]    Sel,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] Step,
    output logic [7:0]    Result
);

    localparam logic [AW:0]   DEPTH_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   LEN_ZERO  = (AW+1)'(0);
    localparam logic [AW-1:0] STEP_ONE  = AW'(1);
    localparam logic [AW-1:0] STEP_ZERO = AW'(0);

    state_t        state_r, state_nxt_s;
    logic [AW-1:0] step_r, step_nxt_s;
    logic [AW:0]   len_r, len_nxt_s;
    logic [7:0]    result_r, result_nxt_s;
    logic [AW:0]   eff_len_s;
    logic          last_step_s;
    logic          final_pass_s;
    logic          wr_en_s;
    logic [1:0]    rd_op_s;

`ifdef OP_SEQ_LOOP_EN
    logic [3:0]    reps_r, reps_nxt_s;
    logic [3:0]    pass_r, pass_nxt_s;
    assign final_pass_s = (pass_r == reps_r);
`else
    assign final_pass_s = 1'b1;
`endif

    // Oversized requests run the whole program once rather than wrapping.
    assign eff_len_s   = (Len > DEPTH_LEN) ? DEPTH_LEN : Len;
    // len_r is never zero while in RUN, so the subtraction cannot wrap there.
    assign last_step_s = ({1'b0, step_r} == (len_r - LEN_ONE));
    // The program is frozen for the duration of a run.
    assign wr_en_s     = WrEn && (state_r != ST_RUN);

    op_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog (
        .clk     (Clk),
        .rst     (Rst),
        .wr_en   (wr_en_s),
        .wr_addr (WrAddr),
        .wr_op   (WrOp),
        .rd_addr (step_r),
        .rd_op   (rd_op_s)
    );

    // Next-state logic: run acceptance, stepping, pass wrap and result capture.
    always_comb begin
        state_nxt_s  = state_r;
        step_nxt_s   = step_r;
        len_nxt_s    = len_r;
        result_nxt_s = result_r;
`ifdef OP_SEQ_LOOP_EN
        reps_nxt_s   = reps_r;
        pass_nxt_s   = pass_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    len_nxt_s  = eff_len_s;
                    step_nxt_s = STEP_ZERO;
`ifdef OP_SEQ_LOOP_EN
                    reps_nxt_s = Reps;
                    pass_nxt_s = 4'd0;
`endif
                    if (eff_len_s != LEN_ZERO) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step_s) begin
                    if (final_pass_s) begin
                        result_nxt_s = MuxOut;
                        state_nxt_s  = ST_DONE;
                    end else begin
                        // Wrap into the next pass with no idle cycle.
                        step_nxt_s = STEP_ZERO;
`ifdef OP_SEQ_LOOP_EN
                        pass_nxt_s = pass_r + 4'd1;
`endif
                    end
                end else begin
                    step_nxt_s = step_r + STEP_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, step, length and result registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r  <= ST_IDLE;
            step_r   <= STEP_ZERO;
            len_r    <= LEN_ZERO;
            result_r <= 8'h00;
`ifdef OP_SEQ_LOOP_EN
            reps_r   <= 4'd0;
            pass_r   <= 4'd0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            step_r   <= step_nxt_s;
            len_r    <= len_nxt_s;
            result_r <= result_nxt_s;
`ifdef OP_SEQ_LOOP_EN
            reps_r   <= reps_nxt_s;
            pass_r   <= pass_nxt_s;
`endif
        end
    end

    assign Sel    = (state_r == ST_RUN) ? rd_op_s : OP_XOR;
    assign Busy   = (state_r == ST_RUN);
    assign Done   = (state_r == ST_DONE);
    assign Step   = step_r;
    assign Result = result_r;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a schedule-based model.
module tb_op_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          Clk, Rst, WrEn, Start;
    logic [AW-1:0] WrAddr;
    logic [1:0]    WrOp;
    logic [AW:0]   Len;
    logic [7:0]    MuxOut;
    logic [1:0]    Sel;
    logic          Busy, Done;
    logic [AW-1:0] Step;
    logic [7:0]    Result;
`ifdef OP_SEQ_LOOP_EN
    logic [3:0]    Reps;
`endif

    op_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .WrEn   (WrEn),
        .WrAddr (WrAddr),
        .WrOp   (WrOp),
        .Start  (Start),
        .Len    (Len),
`ifdef OP_SEQ_LOOP_EN
        .Reps   (Reps),
`endif
        .MuxOut (MuxOut),
        .Sel    (Sel),
        .Busy   (Busy),
        .Done   (Done),
        .Step   (Step),
        .Result (Result)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // On an accepted Start, the whole future output trace of the run is
    // pushed as a list of per-cycle items; each edge pops one item.
    typedef struct {
        logic       busy;
        logic       done;
        logic [1:0] sel;
        int         step;
        logic       last;
    } item_t;

    item_t      sched[$];
    logic [1:0] mprog [DEPTH];
    logic       m_busy = 1'b0, m_done = 1'b0, m_last = 1'b0;
    logic [1:0] m_sel = 2'd0;
    int         m_step = 0;
    logic [7:0] m_result = 8'h00;

    initial begin
        item_t it;
        int    l, np;
        forever begin
            @(posedge Clk or posedge Rst);
            if (Rst) begin
                sched.delete();
                for (int i = 0; i < DEPTH; i++) mprog[i] = 2'd0;
                m_busy = 1'b0; m_done = 1'b0; m_last = 1'b0;
                m_sel = 2'd0; m_step = 0; m_result = 8'h00;
            end else begin
                if (m_last) m_result = MuxOut;
                if (!m_busy && WrEn) mprog[WrAddr] = WrOp;
                if (!m_busy && Start) begin
                    l  = (int'(Len) > DEPTH) ? DEPTH : int'(Len);
                    np = 1;
`ifdef OP_SEQ_LOOP_EN
                    np = int'(Reps) + 1;
`endif
                    sched.delete();
                    if (l > 0) begin
                        for (int p = 0; p < np; p++)
                            for (int k = 0; k < l; k++) begin
                                it.busy = 1'b1; it.done = 1'b0; it.sel = mprog[k];
                                it.step = k; it.last = (p == np - 1) && (k == l - 1);
                                sched.push_back(it);
                            end
                    end
                    it.busy = 1'b0; it.done = 1'b1; it.sel = 2'd0;
                    it.step = (l > 0) ? l - 1 : 0; it.last = 1'b0;
                    sched.push_back(it);
                end
                if (sched.size() > 0) begin
                    it = sched.pop_front();
                    m_busy = it.busy; m_done = it.done; m_sel = it.sel;
                    m_step = it.step; m_last = it.last;
                end else begin
                    m_busy = 1'b0; m_done = 1'b0; m_sel = 2'd0; m_last = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    initial begin
        @(posedge Clk);
        forever begin
            @(negedge Clk);
            chk("model_sel",    int'(Sel),    int'(m_sel));
            chk("model_busy",   int'(Busy),   int'(m_busy));
            chk("model_done",   int'(Done),   int'(m_done));
            chk("model_step",   int'(Step),   m_step);
            chk("model_result", int'(Result), int'(m_result));
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        int n_busy, last_step;
        bit seen_done;
        Rst = 1'b1; WrEn = 1'b0; WrAddr = '0; WrOp = 2'd0; Start = 1'b0;
        Len = '0; MuxOut = 8'h00;
`ifdef OP_SEQ_LOOP_EN
        Reps = 4'd0;
`endif
        next_cycle();
        chk("rst_sel", int'(Sel), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_step", int'(Step), 0);
        chk("rst_result", int'(Result), 0);
        Rst = 1'b0;

        // Basic run: program [1,3,0], Len=3.
        next_cycle(); WrEn = 1'b1; WrAddr = 3'd0; WrOp = 2'd1;
        next_cycle(); WrAddr = 3'd1; WrOp = 2'd3;
        next_cycle(); WrAddr = 3'd2; WrOp = 2'd0;
        next_cycle(); WrEn = 1'b0; Start = 1'b1; Len = 4'd3;
        next_cycle(); Start = 1'b0;
        @(negedge Clk); chk("basic_sel1", int'(Sel), 1); chk("basic_busy1", int'(Busy), 1);
        next_cycle();
        @(negedge Clk); chk("basic_sel2", int'(Sel), 3);
        next_cycle(); MuxOut = 8'hA5;
        @(negedge Clk); chk("basic_sel3", int'(Sel), 0); chk("basic_busy3", int'(Busy), 1);
        next_cycle(); MuxOut = 8'h00;
        @(negedge Clk); chk("basic_done4", int'(Done), 1); chk("basic_result", int'(Result), 8'hA5);
        chk("basic_busy4", int'(Busy), 0); chk("basic_step4", int'(Step), 2);
        next_cycle();
        @(negedge Clk); chk("basic_done5", int'(Done), 0);

        // Reset in the middle of a run.
        next_cycle(); Start = 1'b1; Len = 4'd3;
        next_cycle(); Start = 1'b0;
        next_cycle(); Rst = 1'b1;
        #1;
        chk("midrst_sel", int'(Sel), 0); chk("midrst_busy", int'(Busy), 0);
        chk("midrst_done", int'(Done), 0); chk("midrst_step", int'(Step), 0);
        chk("midrst_result", int'(Result), 0);
        next_cycle(); Rst = 1'b0;
        @(negedge Clk); chk("midrst_nodone", int'(Done), 0);

        // Oversize length clamps to DEPTH.
        next_cycle(); Start = 1'b1; Len = 4'd9;
        next_cycle(); Start = 1'b0;
        n_busy = 0; last_step = -1; seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (Busy) begin n_busy++; last_step = int'(Step); end
            if (Done) begin seen_done = 1'b1; break; end
            next_cycle();
        end
        chk("len9_done_seen", int'(seen_done), 1);
        chk("len9_busy_cycles", n_busy, 8);
        chk("len9_last_step", last_step, 7);

        // Start and WrEn during RUN are ignored; back-to-back rerun.
        next_cycle(); WrEn = 1'b1; WrAddr = 3'd1; WrOp = 2'd3;
        next_cycle(); WrEn = 1'b0; Start = 1'b1; Len = 4'd2;
        next_cycle(); Len = 4'd1; WrEn = 1'b1; WrAddr = 3'd1; WrOp = 2'd2;
        @(negedge Clk); chk("ign_sel1", int'(Sel), 0);
        next_cycle(); Start = 1'b0; WrEn = 1'b0; MuxOut = 8'h3C;
        @(negedge Clk); chk("ign_sel2", int'(Sel), 3); chk("ign_busy2", int'(Busy), 1);
        next_cycle(); MuxOut = 8'h00; Start = 1'b1; Len = 4'd2;
        @(negedge Clk); chk("ign_done3", int'(Done), 1); chk("ign_result", int'(Result), 8'h3C);
        next_cycle(); Start = 1'b0;
        @(negedge Clk); chk("b2b_busy", int'(Busy), 1); chk("b2b_sel0", int'(Sel), 0);
        next_cycle(); MuxOut = 8'h77;
        @(negedge Clk); chk("rerun_old_prog1", int'(Sel), 3);
        next_cycle(); MuxOut = 8'h00;
        @(negedge Clk); chk("rerun_done", int'(Done), 1);

        // Zero length: Done next cycle, Result untouched.
        next_cycle(); Start = 1'b1; Len = 4'd0;
        next_cycle(); Start = 1'b0;
        @(negedge Clk); chk("len0_done", int'(Done), 1); chk("len0_busy", int'(Busy), 0);
        chk("len0_result", int'(Result), 8'h77);

        // Write collides with Start: step 0 sees the new opcode.
        next_cycle(); WrEn = 1'b1; WrAddr = 3'd0; WrOp = 2'd2; Start = 1'b1; Len = 4'd1;
        next_cycle(); WrEn = 1'b0; Start = 1'b0;
        @(negedge Clk); chk("coll_sel", int'(Sel), 2); chk("coll_busy", int'(Busy), 1);
        next_cycle();
        @(negedge Clk); chk("coll_done", int'(Done), 1);

`ifdef OP_SEQ_LOOP_EN
        // Three passes of [1,3].
        next_cycle(); WrEn = 1'b1; WrAddr = 3'd0; WrOp = 2'd1;
        next_cycle(); WrAddr = 3'd1; WrOp = 2'd3;
        next_cycle(); WrEn = 1'b0; Start = 1'b1; Len = 4'd2; Reps = 4'd2;
        for (int k = 1; k <= 7; k++) begin
            next_cycle(); Start = 1'b0; Reps = 4'd0;
            @(negedge Clk);
            if (k <= 6) begin
                chk("loop_sel", int'(Sel), (k % 2 == 1) ? 1 : 3);
                chk("loop_busy", int'(Busy), 1);
            end else begin
                chk("loop_done", int'(Done), 1);
            end
        end
`endif

        // Randomized phase, checked by the model process.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            Rst    = ($urandom_range(0, 199) == 0);
            Start  = ($urandom_range(0, 3) == 0);
            Len    = AW'(0) + (AW+1)'($urandom_range(0, 10));
            WrEn   = $urandom_range(0, 1) == 1;
            WrAddr = AW'($urandom_range(0, DEPTH - 1));
            WrOp   = 2'($urandom_range(0, 3));
            MuxOut = 8'($urandom_range(0, 255));
`ifdef OP_SEQ_LOOP_EN
            Reps   = 4'($urandom_range(0, 3));
`endif
        end
        next_cycle(); Rst = 1'b0; Start = 1'b0; WrEn = 1'b0;
        @(negedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/op_sequencer.md
# op_sequencer

Programmable controller for the 8-bit two-register logic-op datapath (Lab6). It stores a short program of 2-bit opcodes and, on `Start`, drives the datapath `Sel` input one opcode per clock. It captures the datapath `MuxOut` value on the final step as `Result` and signals completion with a one-cycle `Done` pulse. It sits between the host and the datapath and is the only block that drives `Sel`.

## Interface
Parameters:
- `DEPTH`, default 8: program length in entries; must be a power of two, at least 2.
- `AW`, default `$clog2(DEPTH)`: program address width.

Ports:
- `Clk`  in  1  single clock, all state updates on posedge.
- `Rst`  in  1  reset, asynchronous and active-high.
- `WrEn`  in  1  program write strobe.
- `WrAddr`  in  AW  program write address.
- `WrOp`  in  2  opcode to write.
- `Start`  in  1  run request, sampled on posedge.
- `Len`  in  AW+1  number of steps, sampled with `Start`.
- `MuxOut`  in  8  datapath result.
- `Sel`  out  2  datapath opcode select.
- `Busy`  out  1  high while in RUN.
- `Done`  out  1  one-cycle completion pulse.
- `Step`  out  AW  current program index.
- `Result`  out  8  `MuxOut` captured on the last step.

## Operation
- Opcodes: 0 = XOR, 1 = OR, 2 = XNOR, 3 = AND.
- Reset (async, immediate): state IDLE, `Sel`=0, `Busy`=0, `Done`=0, `Step`=0, `Result`=0x00, all program entries = 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: `Sel`=0. On `Start`=1, latch the effective length and set `Step`=0.
  - If effective length > 0, go to RUN.
  - If effective length = 0, go to DONE and leave `Result` unchanged.
- Effective length: if `Len` > `DEPTH`, clamp to `DEPTH`; otherwise use `Len`.
- RUN: `Sel` = prog[`Step`] (combinational read of the registered memory), `Busy`=1.
  - If `Step` = length-1: capture `Result` <= `MuxOut` and go to DONE.
  - Otherwise: `Step` <= `Step`+1.
- DONE: `Done`=1, `Busy`=0, `Sel`=0. `Start` here is accepted exactly as in IDLE; otherwise go to IDLE. `Step` holds its last value until the next `Start`.
- Program writes:
  - Accepted in IDLE and DONE only; `WrEn` in RUN is ignored (program frozen).
  - `WrEn` together with `Start` in IDLE: the write commits at the same edge, so step 0 uses the new value if `WrAddr`=0.
- `Start` while in RUN is ignored; there is no queueing.
- `Rst` during RUN aborts immediately. No `Done` is produced and `Result` clears to 0x00.

## Timing
- `Start` sampled high at edge E0: RUN occupies cycles 1..L, with `Sel`=prog[k] in cycle k+1.
- `Result` updates at the edge closing cycle L.
- `Done`=1 in cycle L+1.
- Latency from `Start` to `Done` = L+1 cycles (1 cycle when L=0).
- `Busy`, `Done`, `Sel`, `Step`, `Result` are registered or derived only from registered state; there is no combinational path from `Start` to any output.
- Back-to-back runs: `Start` in the DONE cycle puts RUN in the next cycle, so the gap is 1 cycle.

## Configuration
- `OP_SEQ_LOOP_EN` defined:
  - Adds input `Reps` [3:0], sampled with `Start`.
  - The program runs `Reps`+1 passes; `Step` wraps from length-1 to 0 between passes with no idle cycle.
  - `Result` is captured only on the last step of the final pass.
  - Latency = (`Reps`+1)·L+1 cycles.
- `OP_SEQ_LOOP_EN` undefined: the port is absent and the program runs a single pass.

## Structure
- Package `op_seq_pkg` holds:
  - Opcode localparams `OP_XOR`, `OP_OR`, `OP_XNOR`, `OP_AND`.
  - State encoding `ST_IDLE`=0, `ST_RUN`=1, `ST_DONE`=2.
- Sub-module `op_prog_mem`: DEPTH×2 register file with async-reset clear, one write port and one combinational read port.
- The FSM, step counter and result register live in `op_sequencer`.

## Test plan
- Reset mid-run: program [1,3,0], `Len`=3, assert `Rst` in cycle 2 -> all outputs 0 at once, no `Done`, `Sel`=0.
- Basic run: write [1,3,0] at addresses 0..2, `Start` with `Len`=3 at cycle 0 -> `Sel`=1,3,0 in cycles 1–3, `Busy` high in cycles 1–3, `MuxOut`=0xA5 stub in cycle 3 gives `Result`=0xA5, `Done` in cycle 4 only.
- Zero and oversize length:
  - `Len`=0 -> `Done` in cycle 1, `Busy` never high, `Result` unchanged.
  - `Len`=9 with DEPTH=8 -> exactly 8 RUN cycles, `Step` 0..7.
- Ignored requests: `Start` and `WrEn` (addr 1, op 2) issued during RUN -> no restart; a rerun still shows the old prog[1].
- Write/start collision and back-to-back:
  - `WrEn` addr 0 op 2 together with `Start` -> first `Sel`=2.
  - `Start` in the DONE cycle -> RUN resumes in the next cycle.
- Loop (with `OP_SEQ_LOOP_EN`): `Len`=2, `Reps`=2, program [1,3] -> `Sel` 1,3,1,3,1,3, `Done` in cycle 7.
